// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
//   Shared types and constants for the 8-digit multiplexed 7-segment scan
//   controller.
//   - scan_state_t : per-slot scan phase (BLANK -> ON -> OFF, or BLANK -> OFF)
//   - ALL_OFF_SEG  : cathode pattern with every segment dark (active-low)
//   - HEX_GLYPH    : 16-entry hex glyph table, bit order {g,f,e,d,c,b,a},
//                    1 = segment lit
//   - hex_glyph()  : table lookup helper
package sevenseg_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    ON    = 2'd1,
    OFF   = 2'd2
  } scan_state_t;

  localparam logic [6:0] ALL_OFF_SEG = 7'h7F;

  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    return HEX_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// sevenseg_hex_decode
//   Combinational nibble -> hex glyph decoder. Used by the scan controller
//   only when SEVENSEG_HEX_DECODE_EN is defined.
//   Ports:
//     nibble_i [3:0] : hex value 0..F
//     glyph_o  [6:0] : {g,f,e,d,c,b,a}, 1 = segment lit
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = hex_glyph(nibble_i);
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//   Multiplexed scan controller for an 8-digit, dual-cathode-bank 7-segment
//   display. Keeps a shadow glyph buffer (written through a valid/ready port)
//   and an active buffer (what is scanned out). A commit pulse copies shadow
//   to active at the next slot boundary. Each digit slot starts with an
//   anti-ghost blanking interval, then lights the digit for a PWM on-time
//   proportional to brightness, then stays dark for the rest of the slot.
//   Digits 0-3 drive bank 0 (seg0/dp0), digits 4-7 drive bank 1 (seg1/dp1).
//
//   Build option: define SEVENSEG_HEX_DECODE_EN to treat wr_data as
//   {dp, 3'b000, nibble} and store the decoded hex glyph instead of raw data.
//
//   Parameters:
//     SCAN_DIV   : clk cycles per digit slot (>= BLANK_CYC+16)
//     BLANK_CYC  : cycles at slot start with all anodes off (>= 1)
//     NUM_DIGITS : digit count, 8 in this revision
//
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     wr_valid/wr_ready   : shadow-buffer write handshake
//     wr_digit, wr_data   : write target and glyph {dp,g,f,e,d,c,b,a}
//     commit, commit_done : shadow->active copy request / completion pulse
//     brightness          : 0 = dark, 15 = max, sampled at slot start
//     an                  : anodes, active-low
//     seg0/dp0, seg1/dp1  : bank cathodes, active-low
//     dbg_state           : current scan phase, for observation only
//
//   Handshake: a write transfers on any rising clk edge where wr_valid and
//   wr_ready are both high; wr_valid may be held every cycle for back-to-back
//   writes. wr_ready is low while a commit is pending, and a write presented
//   then is dropped, not stalled.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_digit,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  output logic        commit_done,
  input  logic [3:0]  brightness,
  output logic [7:0]  an,
  output logic [6:0]  seg0,
  output logic        dp0,
  output logic [6:0]  seg1,
  output logic        dp1,
  output scan_state_t dbg_state
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int W  = (SCAN_DIV - BLANK_CYC) >> 4;

  localparam logic [CW-1:0] LAST_L  = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_L = (CW+1)'(BLANK_CYC);
  localparam logic [CW:0]   W_L     = (CW+1)'(W);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    bright_q, bright_d;
  scan_state_t   state_q, state_d;
  logic          pending_q, pending_d;
  logic          done_q, done_d;
  logic [7:0]    shadow_q [NUM_DIGITS];
  logic [7:0]    shadow_d [NUM_DIGITS];
  logic [7:0]    active_q [NUM_DIGITS];
  logic [7:0]    active_d [NUM_DIGITS];

  logic [7:0]    an_q, an_d;
  logic [6:0]    seg0_q, seg0_d, seg1_q, seg1_d;
  logic          dp0_q, dp0_d, dp1_q, dp1_d;

  // ---------------------------------------------------------------------
  // Write data formatting
  // ---------------------------------------------------------------------
  logic [7:0] store_data;

`ifdef SEVENSEG_HEX_DECODE_EN
  logic [6:0] dec_glyph;
  logic       unused_hex_bits;

  sevenseg_hex_decode u_hex_decode (
    .nibble_i (wr_data[3:0]),
    .glyph_o  (dec_glyph)
  );

  assign store_data      = {wr_data[7], dec_glyph};
  assign unused_hex_bits = ^wr_data[6:4];
`else
  assign store_data = wr_data;
`endif

  // ---------------------------------------------------------------------
  // Slot counter, digit index, brightness sample
  // ---------------------------------------------------------------------
  logic          wrap;
  logic [3:0]    eff_bright;
  logic [CW:0]   on_end;
  logic [CW:0]   cnt_next_ext;

  assign wrap = (cnt_q == LAST_L);

  always_comb begin
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = wrap ? idx_q + 3'd1 : idx_q;
    bright_d = (cnt_q == '0) ? brightness : bright_q;
  end

  // At slot counter 0 the sample is being taken this cycle, so look through
  // to the input; everywhere else the held value applies.
  assign eff_bright   = (cnt_q == '0) ? brightness : bright_q;
  assign on_end       = BLANK_L + (CW+1)'(eff_bright) * W_L;
  assign cnt_next_ext = {1'b0, cnt_d};

  // ---------------------------------------------------------------------
  // Scan FSM: state_q always describes the phase for the current cnt_q,
  // so next state is decided from cnt_d.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wrap) begin
      state_d = BLANK;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_next_ext == BLANK_L) begin
            state_d = (on_end == BLANK_L) ? OFF : ON;
          end
        end
        ON: begin
          if (cnt_next_ext == on_end) begin
            state_d = OFF;
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  always_comb begin
    logic [7:0] glyph;
    glyph  = active_q[idx_q];
    an_d   = 8'hFF;
    seg0_d = ALL_OFF_SEG;
    dp0_d  = 1'b1;
    seg1_d = ALL_OFF_SEG;
    dp1_d  = 1'b1;
    if (state_q == ON) begin
      an_d[idx_q] = 1'b0;
      if (!idx_q[2]) begin
        {dp0_d, seg0_d} = ~glyph;
      end else begin
        {dp1_d, seg1_d} = ~glyph;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shadow/active buffers and commit
  // ---------------------------------------------------------------------
  logic accept;

  assign accept = wr_valid & ~pending_q;

  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (accept) begin
      shadow_d[wr_digit] = store_data;
    end
    // A commit raised while one is already pending is absorbed; the copy
    // happens on the wrap edge, so a commit seen in the wrap cycle itself
    // only becomes pending afterwards and waits for the following wrap.
    if (pending_q) begin
      if (wrap) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
        done_d    = 1'b1;
      end
    end else if (commit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      bright_q  <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      an_q      <= 8'hFF;
      seg0_q    <= ALL_OFF_SEG;
      dp0_q     <= 1'b1;
      seg1_q    <= ALL_OFF_SEG;
      dp1_q     <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bright_q  <= bright_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      an_q      <= an_d;
      seg0_q    <= seg0_d;
      dp0_q     <= dp0_d;
      seg1_q    <= seg1_d;
      dp1_q     <= dp1_d;
    end
  end

  assign wr_ready    = ~pending_q;
  assign commit_done = done_q;
  assign an          = an_q;
  assign seg0        = seg0_q;
  assign dp0         = dp0_q;
  assign seg1        = seg1_q;
  assign dp1         = dp1_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl
//   Self-checking bench for sevenseg_scan_ctrl with a short slot
//   (SCAN_DIV=64, BLANK_CYC=16, so the on-time unit W is 3 cycles).
//   A reference model tracks buffers and slot position per clock and queues
//   the expected pin vector; a monitor on the falling edge pops and compares.
module tb_sevenseg_scan_ctrl;
  import sevenseg_pkg::*;

  localparam int SCAN_DIV  = 64;
  localparam int BLANK_CYC = 16;
  localparam int W         = (SCAN_DIV - BLANK_CYC) / 16;
  localparam int FRAME     = SCAN_DIV * 8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_digit = 3'd0;
  logic [7:0]  wr_data = 8'h00;
  logic        commit = 1'b0;
  logic [3:0]  brightness = 4'd0;
  logic        wr_ready;
  logic        commit_done;
  logic [7:0]  an;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  scan_state_t dbg_state;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .NUM_DIGITS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_digit    (wr_digit),
    .wr_data     (wr_data),
    .commit      (commit),
    .commit_done (commit_done),
    .brightness  (brightness),
    .an          (an),
    .seg0        (seg0),
    .dp0         (dp0),
    .seg1        (seg1),
    .dp1         (dp1),
    .dbg_state   (dbg_state)
  );

  // ---------------- reference model ----------------
  // Expected pin vector {an, seg0, dp0, seg1, dp1, wr_ready, commit_done}.
  logic [25:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int         m_cnt = 0;
  int         m_idx = 0;
  int         m_bright = 0;
  bit         m_pending = 1'b0;
  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];

`ifdef SEVENSEG_HEX_DECODE_EN
  localparam logic [6:0] TB_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [7:0] store_of(input logic [7:0] d);
    return {d[7], TB_HEX[d[3:0]]};
  endfunction
`else
  function automatic logic [7:0] store_of(input logic [7:0] d);
    return d;
  endfunction
`endif

  always @(posedge clk) begin
    logic [7:0] an_e;
    logic [7:0] bank0_e, bank1_e;
    logic [7:0] g;
    bit         lit, wrap_e, done_e;
    if (reset) begin
      m_cnt = 0;
      m_idx = 0;
      m_bright = 0;
      m_pending = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = 8'h00;
        m_active[i] = 8'h00;
      end
      exp_q.push_back({8'hFF, 7'h7F, 1'b1, 7'h7F, 1'b1, 1'b1, 1'b0});
    end else begin
      // Pins after this edge show the slot position held before it.
      lit = (m_cnt >= BLANK_CYC) && (m_cnt < BLANK_CYC + m_bright * W);
      an_e    = 8'hFF;
      bank0_e = 8'hFF;
      bank1_e = 8'hFF;
      if (lit) begin
        an_e[m_idx] = 1'b0;
        g = ~m_active[m_idx];
        if (m_idx < 4) bank0_e = g;
        else           bank1_e = g;
      end
      wrap_e = (m_cnt == SCAN_DIV - 1);
      done_e = 1'b0;
      if (m_pending) begin
        if (wrap_e) begin
          m_active  = m_shadow;
          m_pending = 1'b0;
          done_e    = 1'b1;
        end
      end else begin
        if (wr_valid) m_shadow[wr_digit] = store_of(wr_data);
        if (commit) m_pending = 1'b1;
      end
      if (m_cnt == 0) m_bright = int'(brightness);
      if (wrap_e) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
      exp_q.push_back({an_e, bank0_e[6:0], bank0_e[7], bank1_e[6:0], bank1_e[7],
                       !m_pending, done_e});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [25:0] e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {an, seg0, dp0, seg1, dp1, wr_ready, commit_done};
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pins @%0t: got an=%h seg0=%h dp0=%b seg1=%h dp1=%b rdy=%b done=%b, expected an=%h seg0=%h dp0=%b seg1=%h dp1=%b rdy=%b done=%b",
                 $time, got[25:18], got[17:11], got[10], got[9:3], got[2], got[1], got[0],
                 e[25:18], e[17:11], e[10], e[9:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [2:0] d, input logic [7:0] v);
    wr_valid = 1'b1;
    wr_digit = d;
    wr_data  = v;
    idle(1);
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    idle(1);
    commit = 1'b0;
  endtask

  // Waits (bounded) for the model to show no commit in flight.
  task automatic wait_ready();
    int k;
    k = 0;
    while (m_pending && k < 2 * SCAN_DIV) begin
      idle(1);
      k++;
    end
  endtask

  task automatic wait_cnt(input int c);
    int k;
    k = 0;
    while (m_cnt != c && k < SCAN_DIV) begin
      idle(1);
      k++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Full brightness, digit 0 = "0"
    brightness = 4'd15;
    write(3'd0, 8'h3F);
    do_commit();
    idle(2 * FRAME);

    // Dark for a whole frame
    brightness = 4'd0;
    idle(FRAME + SCAN_DIV);

    // Write during pending commit is dropped
    brightness = 4'd15;
    wait_ready();
    write(3'd5, 8'h86);
    do_commit();
    write(3'd5, 8'h00);
    idle(FRAME + SCAN_DIV);

    // Write and commit in the same cycle
    wait_ready();
    wr_valid = 1'b1;
    wr_digit = 3'd2;
    wr_data  = 8'h06;
    commit   = 1'b1;
    idle(1);
    wr_valid = 1'b0;
    commit   = 1'b0;
    idle(FRAME);

    // Commit landing in the wrap cycle, then a doubled commit
    brightness = 4'd7;
    write(3'd1, 8'h5B);
    wait_cnt(SCAN_DIV - 1);
    do_commit();
    idle(2 * SCAN_DIV);
    write(3'd6, 8'hFF);
    do_commit();
    idle(5);
    do_commit();
    idle(3 * SCAN_DIV);

    // Reset in the middle of digit 3's on-time
    brightness = 4'd15;
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      idle(1);
      if (an == 8'hF7) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL digit3_on_wait: an never reached F7 within %0d cycles, required F7", 2 * FRAME);
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(FRAME);

    // Randomized traffic
    for (int k = 0; k < 6000; k++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_digit = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom_range(0, 255));
      commit   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 63) == 0) brightness = 4'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 2999) == 0);
      idle(1);
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    reset    = 1'b0;

    // Digit 7 = 8'h8A (hex "A" with dp when decoding is enabled)
    brightness = 4'd15;
    wait_ready();
    write(3'd7, 8'h8A);
    do_commit();
    idle(FRAME + 2 * SCAN_DIV);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
